// File: rtl/dq_engine_scheduler_if.sv
// Bundle of every handshake and data signal between the dq engine scheduler,
// its requester channels, the shared alpha-beta/dq engine and the result sink.
// The master modport is the scheduler's view; slave is the surrounding system.
interface dq_engine_scheduler_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4
);
    // Requester side
    logic [NUM_CH-1:0]            ch_valid;
    logic [NUM_CH-1:0]            ch_ready;
    logic [NUM_CH*DATA_WIDTH-1:0] ch_alpha;
    logic [NUM_CH*DATA_WIDTH-1:0] ch_beta;
    logic [NUM_CH*DATA_WIDTH-1:0] ch_theta;
    logic [NUM_CH-1:0]            cfg_aligned;

    // Engine operand handshake
    logic [DATA_WIDTH-1:0]        eng_alpha;
    logic [DATA_WIDTH-1:0]        eng_beta;
    logic [DATA_WIDTH-1:0]        eng_theta;
    logic                         eng_aligned;
    logic                         eng_in_valid;
    logic                         eng_in_ready;

    // Engine result handshake
    logic                         eng_out_valid;
    logic signed [DATA_WIDTH-1:0] eng_d;
    logic signed [DATA_WIDTH-1:0] eng_q;
    logic                         eng_out_ready;

    // Tagged result stream and status
    logic                         res_valid;
    logic                         res_ready;
    logic [2:0]                   res_ch;
    logic signed [DATA_WIDTH-1:0] res_d;
    logic signed [DATA_WIDTH-1:0] res_q;
    logic                         busy;
    logic                         err_timeout;

    modport master (
        input  ch_valid, ch_alpha, ch_beta, ch_theta, cfg_aligned,
        input  eng_in_ready, eng_out_valid, eng_d, eng_q, res_ready,
        output ch_ready, eng_alpha, eng_beta, eng_theta, eng_aligned,
        output eng_in_valid, eng_out_ready,
        output res_valid, res_ch, res_d, res_q, busy, err_timeout
    );

    modport slave (
        output ch_valid, ch_alpha, ch_beta, ch_theta, cfg_aligned,
        output eng_in_ready, eng_out_valid, eng_d, eng_q, res_ready,
        input  ch_ready, eng_alpha, eng_beta, eng_theta, eng_aligned,
        input  eng_in_valid, eng_out_ready,
        input  res_valid, res_ch, res_d, res_q, busy, err_timeout
    );
endinterface

// File: rtl/dq_engine_scheduler.sv
// Round-robin scheduler that shares one alpha-beta/dq engine among NUM_CH
// requester channels. One transaction is in flight at a time: grant, issue
// operands, wait for the engine (bounded by TIMEOUT), deliver a tagged result.
module dq_engine_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                 Clk,
    input  logic                 Reset,
    dq_engine_scheduler_if.master bus
);
    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [2:0]       LAST_CH  = 3'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

    state_t                  r_state;
    logic [2:0]              r_rr_ptr;
    logic [2:0]              r_grant;
    logic [CNT_W-1:0]        r_cnt;
    logic [DATA_WIDTH-1:0]   r_eng_alpha;
    logic [DATA_WIDTH-1:0]   r_eng_beta;
    logic [DATA_WIDTH-1:0]   r_eng_theta;
    logic                    r_eng_aligned;
    logic                    r_eng_in_valid;
    logic                    r_eng_out_ready;
    logic                    r_res_valid;
    logic [2:0]              r_res_ch;
    logic signed [DATA_WIDTH-1:0] r_res_d;
    logic signed [DATA_WIDTH-1:0] r_res_q;
    logic                    r_busy;
    logic                    r_err_timeout;

    logic [7:0]              w_valid8;
    logic                    w_grant_found;
    logic [2:0]              w_grant_idx;
    logic [2:0]              w_cand;
    logic [DATA_WIDTH-1:0]   w_sel_alpha;
    logic [DATA_WIDTH-1:0]   w_sel_beta;
    logic [DATA_WIDTH-1:0]   w_sel_theta;
    logic                    w_sel_aligned;
    logic [NUM_CH-1:0]       w_ch_ready;
    logic [2:0]              w_next_ptr;

    // Channel index base+off, wrapped modulo NUM_CH (off is always < NUM_CH).
    function automatic logic [2:0] wrap_add(input logic [2:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_CH) sum -= NUM_CH;
        return 3'(sum);
    endfunction

    // Widened request vector so a 3-bit channel index always selects exactly.
    assign w_valid8   = 8'(bus.ch_valid);
    assign w_next_ptr = (r_grant == LAST_CH) ? 3'd0 : r_grant + 3'd1;

    // Round-robin search: first requester at or after r_rr_ptr wins.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_cand        = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_cand = wrap_add(r_rr_ptr, i);
            if (!w_grant_found && w_valid8[w_cand]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_cand;
            end
        end
    end

    // Operand mux for the winning channel, using constant slice positions.
    always_comb begin
        w_sel_alpha   = '0;
        w_sel_beta    = '0;
        w_sel_theta   = '0;
        w_sel_aligned = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_grant_idx == 3'(k)) begin
                w_sel_alpha   = bus.ch_alpha[k*DATA_WIDTH +: DATA_WIDTH];
                w_sel_beta    = bus.ch_beta[k*DATA_WIDTH +: DATA_WIDTH];
                w_sel_theta   = bus.ch_theta[k*DATA_WIDTH +: DATA_WIDTH];
                w_sel_aligned = bus.cfg_aligned[k];
            end
        end
    end

    // Accept pulse: same cycle as the grant decision, only while idle and out of reset.
    always_comb begin
        w_ch_ready = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_ch_ready[k] = (r_state == IDLE) && !Reset && w_grant_found &&
                            (w_grant_idx == 3'(k));
        end
    end

    // Transaction FSM with all handshake and data outputs held in registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state         <= IDLE;
            r_rr_ptr        <= '0;
            r_grant         <= '0;
            r_cnt           <= '0;
            r_eng_alpha     <= '0;
            r_eng_beta      <= '0;
            r_eng_theta     <= '0;
            r_eng_aligned   <= 1'b0;
            r_eng_in_valid  <= 1'b0;
            r_eng_out_ready <= 1'b0;
            r_res_valid     <= 1'b0;
            r_res_ch        <= '0;
            r_res_d         <= '0;
            r_res_q         <= '0;
            r_busy          <= 1'b0;
            r_err_timeout   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            case (r_state)
                IDLE: begin
                    if (w_grant_found) begin
                        r_grant        <= w_grant_idx;
                        r_eng_alpha    <= w_sel_alpha;
                        r_eng_beta     <= w_sel_beta;
                        r_eng_theta    <= w_sel_theta;
                        r_eng_aligned  <= w_sel_aligned;
                        r_eng_in_valid <= 1'b1;
                        r_busy         <= 1'b1;
                        r_state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.eng_in_ready) begin
                        r_eng_in_valid  <= 1'b0;
                        r_eng_out_ready <= 1'b1;
                        r_cnt           <= '0;
                        r_state         <= WAIT;
                    end
                end
                WAIT: begin
                    // A result arriving on the expiry cycle still wins over the timeout.
                    if (bus.eng_out_valid) begin
                        r_res_d         <= bus.eng_d;
                        r_res_q         <= bus.eng_q;
                        r_res_ch        <= r_grant;
                        r_eng_out_ready <= 1'b0;
                        r_res_valid     <= 1'b1;
                        r_state         <= DELIVER;
                    end else if (r_cnt == CNT_LAST) begin
                        r_err_timeout   <= 1'b1;
                        r_eng_out_ready <= 1'b0;
                        r_rr_ptr        <= w_next_ptr;
                        r_busy          <= 1'b0;
                        r_state         <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DELIVER: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_rr_ptr    <= w_next_ptr;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ch_ready      = w_ch_ready;
    assign bus.eng_alpha     = r_eng_alpha;
    assign bus.eng_beta      = r_eng_beta;
    assign bus.eng_theta     = r_eng_theta;
    assign bus.eng_aligned   = r_eng_aligned;
    assign bus.eng_in_valid  = r_eng_in_valid;
    assign bus.eng_out_ready = r_eng_out_ready;
    assign bus.res_valid     = r_res_valid;
    assign bus.res_ch        = r_res_ch;
    assign bus.res_d         = r_res_d;
    assign bus.res_q         = r_res_q;
    assign bus.busy          = r_busy;
    assign bus.err_timeout   = r_err_timeout;
endmodule

// File: tb/tb_dq_engine_scheduler.sv
// Self-checking bench for dq_engine_scheduler. The bench plays requesters,
// engine and result sink; expectations come from a round-robin pointer model,
// per-channel operand arrays and the engine values the bench itself returns.
module tb_dq_engine_scheduler;
    localparam int DW  = 32;
    localparam int NCH = 4;
    localparam int TMO = 8;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    dq_engine_scheduler_if #(.DATA_WIDTH(DW), .NUM_CH(NCH)) bus ();

    dq_engine_scheduler #(.DATA_WIDTH(DW), .NUM_CH(NCH), .TIMEOUT(TMO)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model state
    logic [DW-1:0]  m_alpha [NCH];
    logic [DW-1:0]  m_beta  [NCH];
    logic [DW-1:0]  m_theta [NCH];
    logic [NCH-1:0] m_aligned;
    int             m_rr;
    bit             m_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Round-robin rule: first requesting channel at or after rr, wrapping.
    function automatic int pick(input logic [NCH-1:0] req, input int rr);
        for (int k = 0; k < NCH; k++) begin
            if (req[(rr + k) % NCH]) return (rr + k) % NCH;
        end
        return -1;
    endfunction

    task automatic pack_operands();
        for (int k = 0; k < NCH; k++) begin
            bus.ch_alpha[k*DW +: DW] = m_alpha[k];
            bus.ch_beta[k*DW +: DW]  = m_beta[k];
            bus.ch_theta[k*DW +: DW] = m_theta[k];
        end
        bus.cfg_aligned = m_aligned;
    endtask

    task automatic randomize_operands();
        for (int k = 0; k < NCH; k++) begin
            m_alpha[k] = $urandom;
            m_beta[k]  = $urandom;
            m_theta[k] = $urandom;
        end
        m_aligned = NCH'($urandom);
        pack_operands();
    endtask

    // Disturb requester inputs without touching the model copy.
    task automatic scramble_inputs();
        for (int k = 0; k < NCH; k++) begin
            bus.ch_alpha[k*DW +: DW] = $urandom;
            bus.ch_beta[k*DW +: DW]  = $urandom;
            bus.ch_theta[k*DW +: DW] = $urandom;
        end
        bus.cfg_aligned = NCH'($urandom);
        bus.ch_valid    = NCH'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ch_ready"},  bus.ch_ready, 0);
        check({tag, "_eng_alpha"}, bus.eng_alpha, 0);
        check({tag, "_eng_beta"},  bus.eng_beta, 0);
        check({tag, "_eng_theta"}, bus.eng_theta, 0);
        check({tag, "_eng_align"}, bus.eng_aligned, 0);
        check({tag, "_in_valid"},  bus.eng_in_valid, 0);
        check({tag, "_out_ready"}, bus.eng_out_ready, 0);
        check({tag, "_res_valid"}, bus.res_valid, 0);
        check({tag, "_res_ch"},    bus.res_ch, 0);
        check({tag, "_res_d"},     $unsigned(bus.res_d), 0);
        check({tag, "_res_q"},     $unsigned(bus.res_q), 0);
        check({tag, "_busy"},      bus.busy, 0);
        check({tag, "_err"},       bus.err_timeout, 0);
    endtask

    // Asynchronous reset asserted away from the clock edge.
    task automatic do_reset();
        @(posedge Clk);
        #3;
        Reset = 1'b1;
        bus.ch_valid = '1;
        #1;
        check_all_zero("reset");
        @(posedge Clk);
        #2;
        Reset = 1'b0;
        bus.ch_valid = '0;
        m_rr  = 0;
        m_err = 1'b0;
        tick();
    endtask

    // One complete transaction. Starts and ends in IDLE a little after an edge.
    // out_wait >= TMO means the engine never answers.
    task automatic do_txn(input logic [NCH-1:0] req, input bit hold, input int in_wait,
                          input int out_wait, input int res_wait,
                          input logic [DW-1:0] d, input logic [DW-1:0] q);
        int ch;
        int limit;
        bit timeout;
        timeout = (out_wait >= TMO);
        limit   = timeout ? TMO : out_wait;
        bus.ch_valid = req;
        #1;
        ch = pick(req, m_rr);
        check("grant_ready", bus.ch_ready, 64'd1 << ch);
        check("idle_busy", bus.busy, 0);
        tick();
        // Issue phase, engine stalls for in_wait cycles
        for (int i = 0; i <= in_wait; i++) begin
            if (!hold) scramble_inputs();
            bus.eng_in_ready  = (i == in_wait);
            bus.eng_out_valid = 1'($urandom);
            bus.eng_d         = $urandom;
            #1;
            check("issue_in_valid", bus.eng_in_valid, 1);
            check("issue_alpha", bus.eng_alpha, m_alpha[ch]);
            check("issue_beta", bus.eng_beta, m_beta[ch]);
            check("issue_theta", bus.eng_theta, m_theta[ch]);
            check("issue_aligned", bus.eng_aligned, m_aligned[ch]);
            check("issue_ch_ready", bus.ch_ready, 0);
            check("issue_out_ready", bus.eng_out_ready, 0);
            check("issue_busy", bus.busy, 1);
            tick();
        end
        bus.eng_in_ready = 1'b0;
        // Wait phase without a result
        for (int i = 0; i < limit; i++) begin
            bus.eng_out_valid = 1'b0;
            bus.eng_d = $urandom;
            bus.eng_q = $urandom;
            #1;
            check("wait_out_ready", bus.eng_out_ready, 1);
            check("wait_in_valid", bus.eng_in_valid, 0);
            check("wait_res_valid", bus.res_valid, 0);
            tick();
        end
        if (timeout) begin
            bus.ch_valid = '0;
            m_err = 1'b1;
            m_rr  = (ch + 1) % NCH;
            #1;
            check("tmo_err", bus.err_timeout, 1);
            check("tmo_busy", bus.busy, 0);
            check("tmo_res_valid", bus.res_valid, 0);
            check("tmo_out_ready", bus.eng_out_ready, 0);
            return;
        end
        bus.eng_out_valid = 1'b1;
        bus.eng_d = d;
        bus.eng_q = q;
        #1;
        check("result_out_ready", bus.eng_out_ready, 1);
        tick();
        // Deliver phase, sink stalls for res_wait cycles
        for (int i = 0; i <= res_wait; i++) begin
            if (!hold) scramble_inputs();
            bus.eng_out_valid = 1'($urandom);
            bus.eng_d = $urandom;
            bus.eng_q = $urandom;
            bus.res_ready = (i == res_wait);
            #1;
            check("del_res_valid", bus.res_valid, 1);
            check("del_res_ch", bus.res_ch, ch);
            check("del_res_d", $unsigned(bus.res_d), d);
            check("del_res_q", $unsigned(bus.res_q), q);
            check("del_ch_ready", bus.ch_ready, 0);
            check("del_out_ready", bus.eng_out_ready, 0);
            check("del_err", bus.err_timeout, m_err);
            tick();
        end
        bus.res_ready     = 1'b0;
        bus.eng_out_valid = 1'b0;
        bus.ch_valid      = '0;
        m_rr = (ch + 1) % NCH;
        #1;
        check("done_res_valid", bus.res_valid, 0);
        check("done_busy", bus.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NCH-1:0] req;
        bus.ch_valid = '0;
        bus.ch_alpha = '0;
        bus.ch_beta = '0;
        bus.ch_theta = '0;
        bus.cfg_aligned = '0;
        bus.eng_in_ready = 1'b0;
        bus.eng_out_valid = 1'b0;
        bus.eng_d = '0;
        bus.eng_q = '0;
        bus.res_ready = 1'b0;
        do_reset();

        // Single request, minimum latency
        randomize_operands();
        m_alpha[0] = 32'h0100_0000;
        pack_operands();
        do_txn(4'b0001, 1'b1, 0, 0, 0, 32'h0100_0000, 32'h0);

        // Contention from a fresh pointer: 0,1,2,3,0
        do_reset();
        for (int n = 0; n < 5; n++) begin
            randomize_operands();
            do_txn(4'b1111, 1'b1, 0, 0, 0, $urandom, $urandom);
        end

        // Backpressure on both engine input and result sink
        randomize_operands();
        do_txn(4'b0110, 1'b0, 5, 1, 4, $urandom, $urandom);

        // Result on the timeout-expiry cycle is delivered without error
        randomize_operands();
        do_txn(4'b1011, 1'b0, 0, TMO - 1, 0, 32'h8000_0001, 32'hFFFF_FFFF);

        // Randomized traffic
        for (int n = 0; n < 12; n++) begin
            randomize_operands();
            req = NCH'($urandom_range(1, (1 << NCH) - 1));
            do_txn(req, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, TMO - 1),
                   $urandom_range(0, 3), $urandom, $urandom);
        end

        // Engine never answers: sticky error, then the next channel is served
        randomize_operands();
        do_txn(4'b1111, 1'b1, 0, TMO, 0, 32'h0, 32'h0);
        for (int n = 0; n < 3; n++) begin
            randomize_operands();
            do_txn(4'b1111, 1'b0, 1, 2, 1, $urandom, $urandom);
        end

        // Reset in the middle of WAIT abandons the transaction
        randomize_operands();
        bus.ch_valid = 4'b1000;
        tick();
        bus.ch_valid = '0;
        bus.eng_in_ready = 1'b1;
        tick();
        bus.eng_in_ready = 1'b0;
        tick();
        #2;
        Reset = 1'b1;
        #1;
        check_all_zero("rst_mid_wait");
        @(posedge Clk);
        #2;
        Reset = 1'b0;
        m_rr  = 0;
        m_err = 1'b0;
        bus.eng_out_valid = 1'b1;
        bus.eng_d = $urandom;
        bus.eng_q = $urandom;
        for (int n = 0; n < 2; n++) begin
            tick();
            check("late_res_valid", bus.res_valid, 0);
            check("late_busy", bus.busy, 0);
            check("late_out_ready", bus.eng_out_ready, 0);
        end
        bus.eng_out_valid = 1'b0;
        randomize_operands();
        do_txn(4'b1001, 1'b0, 0, 0, 0, $urandom, $urandom);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
